memblk_xlat: RTL and testbench
==============================

# memblk_xlat

Parametrised successor of the tile memory block. NPORTS requesters share one synchronous line RAM. Every request carries a virtual line address, which a shared fully-associative TLB translates to a physical line address. A round-robin arbiter feeds a fixed 2-stage in-order pipeline. The block sits between the tile's load/store ports and local storage, and reports translation faults instead of silently mis-addressing.

## Interface
Parameters:
- NPORTS, 4: number of requester ports (2..16)
- DW, 64: line data width, multiple of 8
- AW, 24: virtual line-address width
- PAW, 12: physical line-address width; RAM depth 2**PAW
- PGBITS, 6: page-offset bits (< PAW)
- NTLB, 8: TLB entries (power of 2)
- TW, 4: request tag width
- TILEX / TILEY, 2'd0: tile coordinates, returned in every response

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- req_valid  in  NPORTS  request present per port
- req_ready  out  NPORTS  request accepted this cycle
- req_we  in  NPORTS  1 = write, 0 = read
- req_addr  in  NPORTS×AW  virtual line address
- req_wdata  in  NPORTS×DW  write data
- req_be  in  NPORTS×DW/8  byte enables for writes
- req_tag  in  NPORTS×TW  opaque tag
- rsp_valid  out  NPORTS  response strobe, one cycle, no backpressure
- rsp_data  out  DW  read data; 0 for writes and faults
- rsp_fault  out  1  translation miss
- rsp_tag  out  TW  tag of the response
- rsp_tile  out  4  {TILEX, TILEY}
- tlb_fill_valid  in  1  write a TLB entry
- tlb_fill_idx  in  log2(NTLB)  entry index
- tlb_fill_vpn  in  AW-PGBITS  virtual page number
- tlb_fill_ppn  in  PAW-PGBITS  physical page number
- tlb_flush  in  1  clear all TLB valid bits

## Operation
- Arbitration (stage A):
  - The round-robin pointer `rr` starts at 0. The grant goes to the first valid port at or after `rr`.
  - `req_ready` is 1 only on the granted port. After a handshake, `rr` becomes grant+1 mod NPORTS.
  - If `tlb_fill_valid` or `tlb_flush` is high, no port is granted and `rr` holds.
- Translation (stage T, 1 cycle after accept):
  - vpn = addr[AW-1:PGBITS]. It is compared against all valid entries in parallel.
  - On multiple hits, the lowest index wins.
  - On a hit, paddr = {ppn, addr[PGBITS-1:0]}.
  - On a miss, the fault bit is set and the op becomes a no-op.
- Access (stage M):
  - Writes update only enabled bytes.
  - Reads use synchronous read-first.
  - Because the pipeline is in order, a write accepted before a read to the same paddr is always visible to that read. No stall is ever needed.
- TLB update:
  - Fill sets valid, vpn and ppn at `tlb_fill_idx`.
  - A flush clears all valid bits.
  - If flush and fill occur in the same cycle, the fill wins for its entry and all other entries are cleared.
  - A stage-T lookup in the same cycle as a fill or flush sees the pre-update contents.
- Response:
  - `rsp_valid` is one-hot on the originating port.
  - `rsp_data`, `rsp_fault`, `rsp_tag` and `rsp_tile` are valid with it.
  - Writes return `rsp_valid` with data 0.
  - A faulting write leaves RAM untouched.

## Timing
- Request accepted at cycle N; response appears at N+2. Throughput is 1 op/cycle with no bubbles.
- `req_ready` is combinational from `req_valid`, `rr`, `tlb_fill_valid` and `tlb_flush`. No other path from an input to `req_ready` exists.
- Reset values: `rsp_valid`=0, `rsp_fault`=0, `rsp_data`=0, `rsp_tag`=0, all TLB valid bits 0, `rr`=0, stage-valid flags 0.
- `req_ready` during reset is 0.
- RAM contents are not reset.
- If reset is asserted while ops are in flight, those ops are dropped: no response, and no write completes after the reset edge.
- The first grant is possible in the first cycle with `rst`=1.

## Structure
- Package `memblk_pkg`:
  - `tlb_entry_t` {valid, vpn, ppn}
  - `pipe_op_t` {valid, port, we, fault, addr, wdata, be, tag}
  - parameter defaults
- Sub-module `memblk_rr_arb`: NPORTS-wide round-robin arbiter with a hold input.
- TLB, pipeline registers and RAM array live in the top module.

## Test plan
- Reset: hold `rst`=0 with `req_valid`=all 1 → `req_ready`=0, `rsp_valid`=0. Release and issue a read → it faults, because the TLB is empty.
- Translation:
  - Fill idx 2 with vpn 0x3, ppn 0x5. Write 0xDEAD to vaddr 0x0C7 on port 1, then read the same address on port 3 in the next cycle.
  - Required: the port-3 response at accept+2 carries 0xDEAD, and RAM location 0x147 changed.
- Byte enables: write be=0x01 with data 0xFF over an existing 0x1122 → read returns 0x11FF.
- Fairness: all 4 ports hold `req_valid` for 8 cycles → grants go 0,1,2,3,0,1,2,3, and each response appears 2 cycles after its grant.
- Fill/flush blocking:
  - Assert `tlb_fill_valid` for one cycle amid continuous requests → zero grants that cycle, and `rr` is unchanged.
  - Flush while a lookup is in stage T → that lookup still hits, and the next request faults.
- Duplicate entries and mid-flight reset:
  - With idx 1 and idx 4 both mapped to vpn 0x3 with different ppns → idx 1's ppn is used.
  - Assert reset one cycle after a write is accepted → no response, and the RAM location is unchanged.

Source files
------------

// File: rtl/memblk_pkg.sv
// Shared defaults and payload types for the translated tile memory block.
package memblk_pkg;

    localparam int unsigned NPORTS_DEF = 4;
    localparam int unsigned DW_DEF     = 64;
    localparam int unsigned AW_DEF     = 24;
    localparam int unsigned PAW_DEF    = 12;
    localparam int unsigned PGBITS_DEF = 6;
    localparam int unsigned NTLB_DEF   = 8;
    localparam int unsigned TW_DEF     = 4;

    localparam int unsigned VPNW_DEF = AW_DEF - PGBITS_DEF;
    localparam int unsigned PPNW_DEF = PAW_DEF - PGBITS_DEF;
    localparam int unsigned PW_DEF   = $clog2(NPORTS_DEF);

    // TLB entry at the default geometry
    typedef struct packed {
        logic                valid;
        logic [VPNW_DEF-1:0] vpn;
        logic [PPNW_DEF-1:0] ppn;
    } tlb_entry_t;

    // Pipeline op at the default geometry
    typedef struct packed {
        logic                  valid;
        logic [PW_DEF-1:0]     port;
        logic                  we;
        logic                  fault;
        logic [AW_DEF-1:0]     addr;
        logic [DW_DEF-1:0]     wdata;
        logic [DW_DEF/8-1:0]   be;
        logic [TW_DEF-1:0]     tag;
    } pipe_op_t;

    // Index width that stays legal for single-entry structures
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/memblk_xlat_if.sv
// Requester-side request/response bundle of the translated memory block.
interface memblk_xlat_if #(
    parameter int unsigned NPORTS = 4,
    parameter int unsigned DW     = 64,
    parameter int unsigned AW     = 24,
    parameter int unsigned TW     = 4
);
    logic [NPORTS-1:0]               req_valid;
    logic [NPORTS-1:0]               req_ready;
    logic [NPORTS-1:0]               req_we;
    logic [NPORTS-1:0][AW-1:0]       req_addr;
    logic [NPORTS-1:0][DW-1:0]       req_wdata;
    logic [NPORTS-1:0][DW/8-1:0]     req_be;
    logic [NPORTS-1:0][TW-1:0]       req_tag;

    logic [NPORTS-1:0]               rsp_valid;
    logic [DW-1:0]                   rsp_data;
    logic                            rsp_fault;
    logic [TW-1:0]                   rsp_tag;
    logic [3:0]                      rsp_tile;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, req_tag,
        input  req_ready, rsp_valid, rsp_data, rsp_fault, rsp_tag, rsp_tile
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, req_tag,
        output req_ready, rsp_valid, rsp_data, rsp_fault, rsp_tag, rsp_tile
    );
endinterface

// File: rtl/memblk_rr_arb.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// pointer moves past the winner; hold blocks all grants and freezes the pointer.
module memblk_rr_arb #(
    parameter int unsigned NPORTS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NPORTS-1:0]         req,
    input  logic                      hold,
    output logic [NPORTS-1:0]         gnt_c,
    output logic [$clog2(NPORTS)-1:0] gnt_idx_c
);
    localparam int unsigned PW = $clog2(NPORTS);

    logic [PW-1:0] rr_q, rr_d;

    always_comb begin
        int unsigned p;
        logic        found;
        gnt_c     = '0;
        gnt_idx_c = '0;
        rr_d      = rr_q;
        found     = 1'b0;
        p         = 0;
        if (!hold) begin
            for (int unsigned i = 0; i < NPORTS; i++) begin
                p = 32'(rr_q) + i;
                if (p >= NPORTS) p = p - NPORTS;
                if (!found && req[p]) begin
                    found     = 1'b1;
                    gnt_c[p]  = 1'b1;
                    gnt_idx_c = PW'(p);
                end
            end
            if (found) begin
                rr_d = (32'(gnt_idx_c) == NPORTS - 1) ? '0 : gnt_idx_c + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rr_q <= '0;
        else      rr_q <= rr_d;
    end

endmodule

// File: rtl/memblk_xlat.sv
// Multi-port line RAM behind a shared fully-associative TLB; round-robin
// accept, one translation stage, RAM access on the response edge.
module memblk_xlat
    import memblk_pkg::*;
#(
    parameter int unsigned NPORTS = NPORTS_DEF,
    parameter int unsigned DW     = DW_DEF,
    parameter int unsigned AW     = AW_DEF,
    parameter int unsigned PAW    = PAW_DEF,
    parameter int unsigned PGBITS = PGBITS_DEF,
    parameter int unsigned NTLB   = NTLB_DEF,
    parameter int unsigned TW     = TW_DEF,
    parameter logic [1:0]  TILEX  = 2'd0,
    parameter logic [1:0]  TILEY  = 2'd0
) (
    input  logic                    clk,
    input  logic                    rst,
    memblk_xlat_if.slave            bus,
    input  logic                    tlb_fill_valid,
    input  logic [$clog2(NTLB)-1:0] tlb_fill_idx,
    input  logic [AW-PGBITS-1:0]    tlb_fill_vpn,
    input  logic [PAW-PGBITS-1:0]   tlb_fill_ppn,
    input  logic                    tlb_flush
);
    localparam int unsigned PW    = $clog2(NPORTS);
    localparam int unsigned VPNW  = AW - PGBITS;
    localparam int unsigned PPNW  = PAW - PGBITS;
    localparam int unsigned BW    = DW / 8;
    localparam int unsigned DEPTH = 2 ** PAW;

    typedef struct packed {
        logic            valid;
        logic [VPNW-1:0] vpn;
        logic [PPNW-1:0] ppn;
    } tlb_ent_t;

    typedef struct packed {
        logic          valid;
        logic [PW-1:0] port;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [BW-1:0] be;
        logic [TW-1:0] tag;
    } op_t;

    logic [NPORTS-1:0] gnt_c;
    logic [PW-1:0]     gnt_idx_c;
    logic              hold_c;

    op_t               t_q, t_d;
    tlb_ent_t          tlb_q [NTLB];
    tlb_ent_t          tlb_d [NTLB];

    logic              hit_c;
    logic [PPNW-1:0]   hit_ppn_c;
    logic [PAW-1:0]    paddr_c;
    logic              ram_we_c, ram_re_c;

    logic [NPORTS-1:0] rsp_valid_q, rsp_valid_d;
    logic              rsp_fault_q, rsp_fault_d;
    logic [TW-1:0]     rsp_tag_q, rsp_tag_d;
    logic [3:0]        rsp_tile_q, rsp_tile_d;
    logic              rd_en_q, rd_en_d;
    logic [DW-1:0]     ram_rdata_q;
    logic [DW-1:0]     ram [DEPTH];

    // TLB maintenance and reset both block acceptance
    assign hold_c = tlb_fill_valid | tlb_flush | ~rst;

    memblk_rr_arb #(.NPORTS(NPORTS)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (bus.req_valid),
        .hold      (hold_c),
        .gnt_c     (gnt_c),
        .gnt_idx_c (gnt_idx_c)
    );

    assign bus.req_ready = gnt_c;

    // Stage A: capture the granted request
    always_comb begin
        t_d = '0;
        if (|gnt_c) begin
            t_d.valid = 1'b1;
            t_d.port  = gnt_idx_c;
            t_d.we    = bus.req_we[gnt_idx_c];
            t_d.addr  = bus.req_addr[gnt_idx_c];
            t_d.wdata = bus.req_wdata[gnt_idx_c];
            t_d.be    = bus.req_be[gnt_idx_c];
            t_d.tag   = bus.req_tag[gnt_idx_c];
        end
    end

    // Stage T: parallel lookup on pre-update TLB contents, lowest index wins
    always_comb begin
        hit_c     = 1'b0;
        hit_ppn_c = '0;
        for (int unsigned i = 0; i < NTLB; i++) begin
            if (!hit_c && tlb_q[i].valid && (tlb_q[i].vpn == t_q.addr[AW-1:PGBITS])) begin
                hit_c     = 1'b1;
                hit_ppn_c = tlb_q[i].ppn;
            end
        end
    end

    assign paddr_c  = {hit_ppn_c, t_q.addr[PGBITS-1:0]};
    assign ram_we_c = t_q.valid &  t_q.we & hit_c;
    assign ram_re_c = t_q.valid & ~t_q.we & hit_c;

    // Flush clears everything, a simultaneous fill still lands its entry
    always_comb begin
        for (int unsigned i = 0; i < NTLB; i++) begin
            tlb_d[i] = tlb_q[i];
            if (tlb_flush) tlb_d[i].valid = 1'b0;
        end
        if (tlb_fill_valid) begin
            tlb_d[tlb_fill_idx].valid = 1'b1;
            tlb_d[tlb_fill_idx].vpn   = tlb_fill_vpn;
            tlb_d[tlb_fill_idx].ppn   = tlb_fill_ppn;
        end
    end

    always_comb begin
        rsp_valid_d = '0;
        if (t_q.valid) rsp_valid_d[t_q.port] = 1'b1;
        rsp_fault_d = t_q.valid & ~hit_c;
        rsp_tag_d   = t_q.valid ? t_q.tag : rsp_tag_q;
        rsp_tile_d  = {TILEX, TILEY};
        rd_en_d     = ram_re_c;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            t_q         <= '0;
            rsp_valid_q <= '0;
            rsp_fault_q <= 1'b0;
            rsp_tag_q   <= '0;
            rsp_tile_q  <= '0;
            rd_en_q     <= 1'b0;
            for (int unsigned i = 0; i < NTLB; i++) tlb_q[i] <= '0;
        end else begin
            t_q         <= t_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_fault_q <= rsp_fault_d;
            rsp_tag_q   <= rsp_tag_d;
            rsp_tile_q  <= rsp_tile_d;
            rd_en_q     <= rd_en_d;
            tlb_q       <= tlb_d;
        end
    end

    // Line RAM: byte-masked write, read-first synchronous read, never reset
    always_ff @(posedge clk) begin
        if (ram_we_c) begin
            for (int unsigned b = 0; b < BW; b++) begin
                if (t_q.be[b]) ram[paddr_c][b*8 +: 8] <= t_q.wdata[b*8 +: 8];
            end
        end
        if (ram_re_c) ram_rdata_q <= ram[paddr_c];
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rd_en_q ? ram_rdata_q : '0;
    assign bus.rsp_fault = rsp_fault_q;
    assign bus.rsp_tag   = rsp_tag_q;
    assign bus.rsp_tile  = rsp_tile_q;

endmodule

// File: tb/tb_memblk_xlat.sv
// Directed bench for memblk_xlat: reset, translation, byte enables, fairness,
// TLB maintenance blocking, flush timing, duplicate entries and mid-flight reset.
module tb_memblk_xlat;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tlb_fill_valid = 1'b0;
    logic        tlb_flush = 1'b0;
    logic [2:0]  tlb_fill_idx = '0;
    logic [17:0] tlb_fill_vpn = '0;
    logic [5:0]  tlb_fill_ppn = '0;

    int checks = 0;
    int errors = 0;

    localparam logic [3:0] TILE_EXP = 4'h6;

    memblk_xlat_if #(.NPORTS(4), .DW(64), .AW(24), .TW(4)) bus ();

    memblk_xlat #(
        .NPORTS(4), .DW(64), .AW(24), .PAW(12), .PGBITS(6),
        .NTLB(8), .TW(4), .TILEX(2'd1), .TILEY(2'd2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .tlb_fill_valid (tlb_fill_valid),
        .tlb_fill_idx   (tlb_fill_idx),
        .tlb_fill_vpn   (tlb_fill_vpn),
        .tlb_fill_ppn   (tlb_fill_ppn),
        .tlb_flush      (tlb_flush)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic set_req(input int p, input logic we, input logic [23:0] a,
                           input logic [63:0] wd, input logic [7:0] be, input logic [3:0] tag);
        bus.req_valid[p] = 1'b1;
        bus.req_we[p]    = we;
        bus.req_addr[p]  = a;
        bus.req_wdata[p] = wd;
        bus.req_be[p]    = be;
        bus.req_tag[p]   = tag;
    endtask

    task automatic tlb_op(input logic fill, input logic flush, input logic [2:0] idx,
                          input logic [17:0] vpn, input logic [5:0] ppn);
        @(negedge clk);
        tlb_fill_valid = fill;
        tlb_flush      = flush;
        tlb_fill_idx   = idx;
        tlb_fill_vpn   = vpn;
        tlb_fill_ppn   = ppn;
        @(negedge clk);
        tlb_fill_valid = 1'b0;
        tlb_flush      = 1'b0;
    endtask

    // Issue one request, wait (bounded) for its grant, return the response seen two cycles later
    task automatic single_op(input int p, input logic we, input logic [23:0] a,
                             input logic [63:0] wd, input logic [7:0] be, input logic [3:0] tag,
                             output logic [3:0] rv, output logic [63:0] rd, output logic rf,
                             output logic [3:0] rt, output logic [3:0] rtile);
        bit acc = 1'b0;
        @(negedge clk);
        bus.req_valid = '0;
        set_req(p, we, a, wd, be, tag);
        for (int k = 0; k < 8 && !acc; k++) begin
            #1;
            if (bus.req_ready[p]) acc = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL accept_timeout port %0d: ready %b, required grant", p, bus.req_ready);
        end
        @(negedge clk);
        bus.req_valid = '0;
        @(negedge clk);
        rv    = bus.rsp_valid;
        rd    = bus.rsp_data;
        rf    = bus.rsp_fault;
        rt    = bus.rsp_tag;
        rtile = bus.rsp_tile;
    endtask

    task automatic test_reset();
        logic [3:0] rv, rt, rtile;
        logic [63:0] rd;
        logic rf;
        for (int p = 0; p < 4; p++) set_req(p, 1'b0, 24'h0C7, 64'h0, 8'h0, 4'(p));
        @(negedge clk);
        checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b, required 0000", bus.req_ready); end
        checks++; if (bus.rsp_valid !== 4'b0000) begin errors++; $display("FAIL reset_rsp_valid: got %b, required 0000", bus.rsp_valid); end
        checks++; if (bus.rsp_fault !== 1'b0) begin errors++; $display("FAIL reset_rsp_fault: got %b, required 0", bus.rsp_fault); end
        checks++; if (bus.rsp_data !== 64'h0) begin errors++; $display("FAIL reset_rsp_data: got %h, required 0", bus.rsp_data); end
        checks++; if (bus.rsp_tag !== 4'h0) begin errors++; $display("FAIL reset_rsp_tag: got %h, required 0", bus.rsp_tag); end
        // First cycle out of reset already grants
        @(negedge clk);
        rst = 1'b1;
        bus.req_valid = '0;
        set_req(0, 1'b0, 24'h0C7, 64'h0, 8'h0, 4'h5);
        #1;
        checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL first_grant: got %b, required 0001", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = '0;
        @(negedge clk);
        rv = bus.rsp_valid; rd = bus.rsp_data; rf = bus.rsp_fault; rt = bus.rsp_tag; rtile = bus.rsp_tile;
        checks++; if (rv !== 4'b0001) begin errors++; $display("FAIL empty_tlb_valid: got %b, required 0001", rv); end
        checks++; if (rf !== 1'b1) begin errors++; $display("FAIL empty_tlb_fault: got %b, required 1", rf); end
        checks++; if (rd !== 64'h0) begin errors++; $display("FAIL empty_tlb_data: got %h, required 0", rd); end
        checks++; if (rt !== 4'h5) begin errors++; $display("FAIL empty_tlb_tag: got %h, required 5", rt); end
        checks++; if (rtile !== TILE_EXP) begin errors++; $display("FAIL rsp_tile: got %h, required %h", rtile, TILE_EXP); end
    endtask

    task automatic test_translation();
        logic [3:0] rv, rt, rtile;
        logic [63:0] rd;
        logic rf;
        tlb_op(1'b1, 1'b0, 3'd2, 18'h3, 6'h5);
        tlb_op(1'b1, 1'b0, 3'd3, 18'h10, 6'h5);
        @(negedge clk);
        set_req(1, 1'b1, 24'h0C7, 64'hDEAD, 8'hFF, 4'h1);
        #1;
        checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL xlat_wr_grant: got %b, required 0010", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = '0;
        set_req(3, 1'b0, 24'h0C7, 64'h0, 8'h0, 4'h2);
        #1;
        checks++; if (bus.req_ready !== 4'b1000) begin errors++; $display("FAIL xlat_rd_grant: got %b, required 1000", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = '0;
        checks++; if (bus.rsp_valid !== 4'b0010) begin errors++; $display("FAIL xlat_wr_rsp_valid: got %b, required 0010", bus.rsp_valid); end
        checks++; if (bus.rsp_data !== 64'h0) begin errors++; $display("FAIL xlat_wr_rsp_data: got %h, required 0", bus.rsp_data); end
        checks++; if (bus.rsp_tag !== 4'h1 || bus.rsp_fault !== 1'b0) begin errors++; $display("FAIL xlat_wr_rsp_tag_fault: got %h/%b, required 1/0", bus.rsp_tag, bus.rsp_fault); end
        @(negedge clk);
        checks++; if (bus.rsp_valid !== 4'b1000) begin errors++; $display("FAIL xlat_rd_rsp_valid: got %b, required 1000", bus.rsp_valid); end
        checks++; if (bus.rsp_data !== 64'hDEAD) begin errors++; $display("FAIL xlat_rd_data: got %h, required dead", bus.rsp_data); end
        checks++; if (bus.rsp_tag !== 4'h2 || bus.rsp_fault !== 1'b0) begin errors++; $display("FAIL xlat_rd_tag_fault: got %h/%b, required 2/0", bus.rsp_tag, bus.rsp_fault); end
        // Alias page 0x10 -> ppn 5 reaches physical line 0x147 as well
        single_op(0, 1'b0, 24'h407, 64'h0, 8'h0, 4'h3, rv, rd, rf, rt, rtile);
        checks++; if (rv !== 4'b0001 || rf !== 1'b0) begin errors++; $display("FAIL alias_rsp: got %b/%b, required 0001/0", rv, rf); end
        checks++; if (rd !== 64'hDEAD) begin errors++; $display("FAIL alias_paddr_147: got %h, required dead", rd); end
    endtask

    task automatic test_byte_enable();
        logic [3:0] rv, rt, rtile;
        logic [63:0] rd;
        logic rf;
        single_op(2, 1'b1, 24'h0C8, 64'h1122, 8'hFF, 4'h4, rv, rd, rf, rt, rtile);
        checks++; if (rv !== 4'b0100 || rd !== 64'h0) begin errors++; $display("FAIL be_full_write: got %b/%h, required 0100/0", rv, rd); end
        single_op(2, 1'b1, 24'h0C8, 64'hFF, 8'h01, 4'h5, rv, rd, rf, rt, rtile);
        checks++; if (rt !== 4'h5 || rf !== 1'b0) begin errors++; $display("FAIL be_partial_write: got %h/%b, required 5/0", rt, rf); end
        single_op(2, 1'b0, 24'h0C8, 64'h0, 8'h0, 4'h6, rv, rd, rf, rt, rtile);
        checks++; if (rd !== 64'h11FF) begin errors++; $display("FAIL be_merge: got %h, required 11ff", rd); end
    endtask

    task automatic test_fairness();
        logic [3:0] rv, rt, rtile, exp_p;
        logic [63:0] rd;
        logic rf;
        // Port 3 last granted leaves the pointer at 0
        single_op(3, 1'b0, 24'h0C7, 64'h0, 8'h0, 4'h0, rv, rd, rf, rt, rtile);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c == 0) for (int p = 0; p < 4; p++) set_req(p, 1'b0, 24'h0C7, 64'h0, 8'h0, 4'(8 + p));
            if (c == 8) bus.req_valid = '0;
            #1;
            if (c < 8) begin
                checks++;
                if (bus.req_ready !== (4'b0001 << (c % 4))) begin errors++; $display("FAIL rr_grant c%0d: got %b, required %b", c, bus.req_ready, 4'b0001 << (c % 4)); end
            end
            exp_p = (c >= 2) ? (4'b0001 << ((c - 2) % 4)) : 4'b0000;
            checks++;
            if (bus.rsp_valid !== exp_p) begin errors++; $display("FAIL rr_rsp_valid c%0d: got %b, required %b", c, bus.rsp_valid, exp_p); end
            if (c >= 2) begin
                checks++;
                if (bus.rsp_tag !== 4'(8 + (c - 2) % 4) || bus.rsp_data !== 64'hDEAD) begin
                    errors++; $display("FAIL rr_rsp_payload c%0d: got %h/%h, required %h/dead", c, bus.rsp_tag, bus.rsp_data, 4'(8 + (c - 2) % 4));
                end
            end
        end
    endtask

    task automatic test_fill_block();
        logic [3:0] rdy_exp [4] = '{4'b0001, 4'b0000, 4'b0010, 4'b0100};
        logic [3:0] rsp_exp [7] = '{4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0100, 4'b0000};
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            if (c == 0) for (int p = 0; p < 4; p++) set_req(p, 1'b0, 24'h0C7, 64'h0, 8'h0, 4'(8 + p));
            if (c == 1) begin
                tlb_fill_valid = 1'b1; tlb_fill_idx = 3'd5; tlb_fill_vpn = 18'h20; tlb_fill_ppn = 6'h9;
            end
            if (c == 2) tlb_fill_valid = 1'b0;
            if (c == 4) bus.req_valid = '0;
            #1;
            if (c < 4) begin
                checks++;
                if (bus.req_ready !== rdy_exp[c]) begin errors++; $display("FAIL fill_block_grant c%0d: got %b, required %b", c, bus.req_ready, rdy_exp[c]); end
            end
            checks++;
            if (bus.rsp_valid !== rsp_exp[c]) begin errors++; $display("FAIL fill_block_rsp c%0d: got %b, required %b", c, bus.rsp_valid, rsp_exp[c]); end
        end
    endtask

    task automatic test_flush_in_flight();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c == 0) set_req(0, 1'b0, 24'h0C7, 64'h0, 8'h0, 4'h3);
            if (c == 1) begin tlb_flush = 1'b1; set_req(0, 1'b0, 24'h0C7, 64'h0, 8'h0, 4'h4); end
            if (c == 2) tlb_flush = 1'b0;
            if (c == 3) bus.req_valid = '0;
            #1;
            if (c < 3) begin
                checks++;
                if (bus.req_ready !== ((c == 1) ? 4'b0000 : 4'b0001)) begin errors++; $display("FAIL flush_grant c%0d: got %b", c, bus.req_ready); end
            end
            if (c == 2) begin
                checks++;
                if (bus.rsp_valid !== 4'b0001 || bus.rsp_tag !== 4'h3 || bus.rsp_fault !== 1'b0 || bus.rsp_data !== 64'hDEAD) begin
                    errors++; $display("FAIL flush_inflight_hit: got %b/%h/%b/%h, required 0001/3/0/dead", bus.rsp_valid, bus.rsp_tag, bus.rsp_fault, bus.rsp_data);
                end
            end
            if (c == 4) begin
                checks++;
                if (bus.rsp_valid !== 4'b0001 || bus.rsp_tag !== 4'h4 || bus.rsp_fault !== 1'b1 || bus.rsp_data !== 64'h0) begin
                    errors++; $display("FAIL flush_after_fault: got %b/%h/%b/%h, required 0001/4/1/0", bus.rsp_valid, bus.rsp_tag, bus.rsp_fault, bus.rsp_data);
                end
            end
        end
    endtask

    task automatic test_dup_entries();
        logic [3:0] rv, rt, rtile;
        logic [63:0] rd;
        logic rf;
        tlb_op(1'b1, 1'b0, 3'd4, 18'h3, 6'h7);
        single_op(1, 1'b1, 24'h0C7, 64'hBEEF, 8'hFF, 4'h7, rv, rd, rf, rt, rtile);
        checks++; if (rv !== 4'b0010 || rf !== 1'b0) begin errors++; $display("FAIL dup_prewrite: got %b/%b, required 0010/0", rv, rf); end
        tlb_op(1'b1, 1'b0, 3'd1, 18'h3, 6'h5);
        single_op(2, 1'b0, 24'h0C7, 64'h0, 8'h0, 4'h8, rv, rd, rf, rt, rtile);
        checks++; if (rd !== 64'hDEAD || rf !== 1'b0) begin errors++; $display("FAIL dup_lowest_index: got %h/%b, required dead/0", rd, rf); end
        // Flush and fill together: only the filled entry survives
        tlb_op(1'b1, 1'b1, 3'd6, 18'h3, 6'h7);
        single_op(3, 1'b0, 24'h0C7, 64'h0, 8'h0, 4'h9, rv, rd, rf, rt, rtile);
        checks++; if (rd !== 64'hBEEF || rf !== 1'b0) begin errors++; $display("FAIL flush_fill_same_cycle: got %h/%b, required beef/0", rd, rf); end
    endtask

    task automatic test_midflight_reset();
        logic [3:0] rv, rt, rtile;
        logic [63:0] rd;
        logic rf;
        @(negedge clk);
        set_req(0, 1'b1, 24'h0C7, 64'h5555, 8'hFF, 4'hA);
        #1;
        checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL midrst_grant: got %b, required 0001", bus.req_ready); end
        @(negedge clk);
        rst = 1'b0;
        bus.req_valid = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (c == 0) rst = 1'b1;
            checks++;
            if (bus.rsp_valid !== 4'b0000) begin errors++; $display("FAIL midrst_no_rsp c%0d: got %b, required 0000", c, bus.rsp_valid); end
        end
        tlb_op(1'b1, 1'b0, 3'd0, 18'h3, 6'h7);
        single_op(1, 1'b0, 24'h0C7, 64'h0, 8'h0, 4'hB, rv, rd, rf, rt, rtile);
        checks++; if (rd !== 64'hBEEF || rf !== 1'b0 || rt !== 4'hB) begin errors++; $display("FAIL midrst_ram_unchanged: got %h/%b/%h, required beef/0/b", rd, rf, rt); end
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_be    = '0;
        bus.req_tag   = '0;
        test_reset();
        test_translation();
        test_byte_enable();
        test_fairness();
        test_fill_block();
        test_flush_in_flight();
        test_dup_entries();
        test_midflight_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
